seat_table: RTL

Clocked, parametrised seat-occupancy table for the seating controller. It stores a student ID, a time stamp and a 2-bit state per seat. A single-outstanding request/response port serves write, release and query operations, with occupancy and duplicate-seat checks. A background sweep engine frees seats whose "away" time exceeds a limit.

---
 rtl/seat_table.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/seat_table.sv
// seat_table: per-seat student ID / time stamp / state table with a request-response port and background expiry sweep.
// Build option: define SEAT_DUP_CHECK_EN to add the cross-seat duplicate-student check on WRITE.
module seat_table #(
  parameter int NUM_SEATS = 32,
  parameter int ID_W      = 32,
  parameter int TIME_W    = 11,
  localparam int SEAT_W   = $clog2(NUM_SEATS)
) (
  input  logic              clk_mem,
  input  logic              rst_mem,
  input  logic [TIME_W-1:0] cur_time,
  input  logic [TIME_W-1:0] limit_time,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [SEAT_W-1:0] req_seat,
  input  logic [ID_W-1:0]   req_student,
  input  logic [1:0]        req_state,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_status,
  output logic [1:0]        rsp_state,
  output logic [ID_W-1:0]   rsp_student,
  output logic [TIME_W-1:0] rsp_elapsed,
  output logic [SEAT_W:0]   free_count,
  output logic              expire_pulse,
  output logic [SEAT_W-1:0] expire_seat
);

  localparam int CNT_W = SEAT_W + 1;

  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_AWAY   = 2'd1;
  localparam logic [1:0] ST_SEATED = 2'd3;

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_RELEASE = 2'd1;
  localparam logic [1:0] OP_QUERY   = 2'd2;
  localparam logic [1:0] OP_BAD     = 2'd3;

  localparam logic [2:0] RS_OK        = 3'd0;
  localparam logic [2:0] RS_BAD_SEAT  = 3'd1;
  localparam logic [2:0] RS_OCCUPIED  = 3'd2;
  localparam logic [2:0] RS_DUPLICATE = 3'd3;
  localparam logic [2:0] RS_BAD_OP    = 3'd4;

  typedef enum logic [1:0] {FSM_IDLE, FSM_EXEC, FSM_RESP} fsm_e;

  fsm_e fsm_q, fsm_d;

  logic [1:0]        seat_st_q    [NUM_SEATS];
  logic [ID_W-1:0]   seat_id_q    [NUM_SEATS];
  logic [TIME_W-1:0] seat_stamp_q [NUM_SEATS];
  logic [SEAT_W-1:0] ptr_q;

  logic [1:0]        op_q;
  logic [SEAT_W-1:0] seat_q;
  logic [ID_W-1:0]   student_q;
  logic [1:0]        new_st_q;

  logic              in_range;
  logic [SEAT_W-1:0] seat_idx;
  logic [1:0]        cur_st;
  logic [ID_W-1:0]   cur_id;
  logic [TIME_W-1:0] cur_elapsed;
  logic              dup_hit;

  logic              tbl_write, tbl_release, exec_touch;
  logic [2:0]        ex_status;
  logic [1:0]        ex_state;
  logic [ID_W-1:0]   ex_student;
  logic [TIME_W-1:0] ex_elapsed;

  logic [TIME_W-1:0] sweep_elapsed;
  logic              sweep_free;
  logic              free_dec, free_inc_exec;

  always_ff @(posedge clk_mem or posedge rst_mem) begin
    if (rst_mem) fsm_q <= FSM_IDLE;
    else         fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d     = fsm_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (fsm_q)
      FSM_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) fsm_d = FSM_EXEC;
      end
      FSM_EXEC: fsm_d = FSM_RESP;
      FSM_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) fsm_d = FSM_IDLE;
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk_mem or posedge rst_mem) begin
    if (rst_mem) begin
      op_q      <= '0;
      seat_q    <= '0;
      student_q <= '0;
      new_st_q  <= '0;
    end else if (fsm_q == FSM_IDLE && req_valid) begin
      op_q      <= req_op;
      seat_q    <= req_seat;
      student_q <= req_student;
      new_st_q  <= req_state;
    end
  end

  // Out-of-range seats are redirected to seat 0 so the table read stays in bounds.
  assign in_range    = (int'(seat_q) < NUM_SEATS);
  assign seat_idx    = in_range ? seat_q : '0;
  assign cur_st      = seat_st_q[seat_idx];
  assign cur_id      = seat_id_q[seat_idx];
  assign cur_elapsed = cur_time - seat_stamp_q[seat_idx];

`ifdef SEAT_DUP_CHECK_EN
  localparam logic [1:0] ST_RESERVED = 2'd2;
  logic dup_any;

  always_comb begin
    dup_any = 1'b0;
    for (int i = 0; i < NUM_SEATS; i++) begin
      if (SEAT_W'(i) != seat_idx && seat_st_q[i] != ST_FREE && seat_id_q[i] == student_q)
        dup_any = 1'b1;
    end
  end

  assign dup_hit = dup_any && (new_st_q == ST_SEATED || new_st_q == ST_RESERVED);
`else
  assign dup_hit = 1'b0;
`endif

  always_comb begin
    tbl_write   = 1'b0;
    tbl_release = 1'b0;
    exec_touch  = 1'b0;
    ex_status   = RS_OK;
    ex_state    = cur_st;
    ex_student  = cur_id;
    ex_elapsed  = cur_elapsed;
    if (op_q == OP_BAD) begin
      ex_status  = RS_BAD_OP;
      ex_state   = '0;
      ex_student = '0;
      ex_elapsed = '0;
    end else if (!in_range) begin
      ex_status  = RS_BAD_SEAT;
      ex_state   = '0;
      ex_student = '0;
      ex_elapsed = '0;
    end else begin
      exec_touch = (fsm_q == FSM_EXEC) && (seat_idx == ptr_q);
      case (op_q)
        OP_WRITE: begin
          if (cur_st == ST_SEATED && new_st_q == ST_SEATED && cur_id != student_q) begin
            ex_status = RS_OCCUPIED;
          end else if (dup_hit) begin
            ex_status = RS_DUPLICATE;
          end else begin
            tbl_write  = (fsm_q == FSM_EXEC);
            ex_state   = new_st_q;
            ex_student = student_q;
            ex_elapsed = '0;
          end
        end
        OP_RELEASE: begin
          tbl_release = (fsm_q == FSM_EXEC);
          ex_state    = ST_FREE;
        end
        OP_QUERY: ;
        default: ;
      endcase
    end
  end

  // A request being executed on the swept seat takes precedence over the expiry.
  assign sweep_elapsed = cur_time - seat_stamp_q[ptr_q];
  assign sweep_free    = (seat_st_q[ptr_q] == ST_AWAY) && (sweep_elapsed > limit_time) && !exec_touch;

  assign free_dec      = tbl_write && cur_st == ST_FREE && new_st_q != ST_FREE;
  assign free_inc_exec = (tbl_write && cur_st != ST_FREE && new_st_q == ST_FREE) ||
                         (tbl_release && cur_st != ST_FREE);

  always_ff @(posedge clk_mem or posedge rst_mem) begin
    if (rst_mem) begin
      for (int i = 0; i < NUM_SEATS; i++) begin
        seat_st_q[i]    <= ST_FREE;
        seat_id_q[i]    <= '0;
        seat_stamp_q[i] <= '0;
      end
    end else begin
      if (sweep_free) seat_st_q[ptr_q] <= ST_FREE;
      if (tbl_write) begin
        seat_st_q[seat_idx]    <= new_st_q;
        seat_id_q[seat_idx]    <= student_q;
        seat_stamp_q[seat_idx] <= cur_time;
      end
      if (tbl_release) seat_st_q[seat_idx] <= ST_FREE;
    end
  end

  always_ff @(posedge clk_mem or posedge rst_mem) begin
    if (rst_mem) begin
      ptr_q        <= '0;
      expire_pulse <= 1'b0;
      expire_seat  <= '0;
      free_count   <= CNT_W'(NUM_SEATS);
    end else begin
      ptr_q        <= (int'(ptr_q) == NUM_SEATS - 1) ? '0 : ptr_q + 1'b1;
      expire_pulse <= sweep_free;
      if (sweep_free) expire_seat <= ptr_q;
      free_count   <= free_count + CNT_W'(free_inc_exec) + CNT_W'(sweep_free) - CNT_W'(free_dec);
    end
  end

  always_ff @(posedge clk_mem or posedge rst_mem) begin
    if (rst_mem) begin
      rsp_status  <= '0;
      rsp_state   <= '0;
      rsp_student <= '0;
      rsp_elapsed <= '0;
    end else if (fsm_q == FSM_EXEC) begin
      rsp_status  <= ex_status;
      rsp_state   <= ex_state;
      rsp_student <= ex_student;
      rsp_elapsed <= ex_elapsed;
    end
  end

endmodule
